mulvec_pipe: RTL and testbench

Parametrised, pipelined vector integer multiplier with a valid/ready handshake, per-element masking and a tag passthrough. It is the successor of the single-stage vector multiplier in the vector execute unit. It generalises vector width and pipeline depth, and adds a signed×unsigned high mode, backpressure, flush and an illegal-width error. It sits between the vector issue stage and the vector writeback arbiter.

---
 rtl/mulvec_pipe.sv | 184 ++++++++++++++++++
 tb/tb_mulvec_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mulvec_pipe.sv
// mulvec_pipe: pipelined vector integer multiplier, per-element masking,
// valid/ready handshake, flush, tag passthrough and illegal-SEW error.
module mulvec_pipe #(
  parameter int VLEN   = 128,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [VLEN-1:0]                  srca_in,
  input  logic [VLEN-1:0]                  srcb_in,
  input  logic [VLEN-1:0]                  vd_in,
  input  logic [2:0]                       sel_in,
  input  logic [1:0]                       op_in,
  input  logic [VLEN/8-1:0]                mask_in,
  input  logic                             mask_agn_in,
  input  logic [TAG_W-1:0]                 tag_in,
  input  logic                             flush_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [VLEN-1:0]                  result_out,
  output logic                             err_out,
  output logic [TAG_W-1:0]                 tag_out,
  output logic [$clog2(STAGES+1)-1:0]      occupancy_out
);

  localparam int NM    = VLEN / 8;
  localparam int LOG   = $clog2(VLEN / 8);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic              adv;
  logic              acc;
  logic              hs;
  logic [STAGES-1:0] v_q;
  logic [OCC_W-1:0]  occ_q;

  logic [VLEN-1:0]   a_q;
  logic [VLEN-1:0]   b_q;
  logic [VLEN-1:0]   vd_q;
  logic [2:0]        sel_q;
  logic [1:0]        op_q;
  logic [NM-1:0]     mask_q;
  logic              agn_q;
  logic [TAG_W-1:0]  tag0_q;

  logic [VLEN-1:0]   res_q [1:STAGES-1];
  logic              err_q [1:STAGES-1];
  logic [TAG_W-1:0]  tag_q [1:STAGES-1];

  logic              a_sg;
  logic              b_sg;
  logic              hi;
  logic [VLEN-1:0]   res_by [LOG+1];
  logic [VLEN-1:0]   res_c;
  logic              err_c;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv & !flush_in;
  assign acc       = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign out_valid = v_q[STAGES-1];

  assign result_out    = res_q[STAGES-1];
  assign err_out       = err_q[STAGES-1];
  assign tag_out       = tag_q[STAGES-1];
  assign occupancy_out = occ_q;

  // op encoding: bit0 set means A is signed; only MULH has B signed
  assign a_sg = op_q[0];
  assign b_sg = (op_q == 2'b01);
  assign hi   = |op_q;

  // one multiplier array per legal SEW; the selected one is muxed below
  for (genvar s = 0; s <= LOG; s++) begin : g_sew
    localparam int SEW = 8 << s;
    for (genvar e = 0; e < VLEN / SEW; e++) begin : g_el
      logic [SEW-1:0]   a;
      logic [SEW-1:0]   b;
      logic [SEW-1:0]   d;
      logic [SEW-1:0]   r;
      logic [2*SEW-1:0] ax;
      logic [2*SEW-1:0] bx;
      logic [2*SEW-1:0] p;

      // extend, multiply, pick half, then apply the element mask
      always_comb begin
        a  = a_q[e*SEW +: SEW];
        b  = b_q[e*SEW +: SEW];
        d  = vd_q[e*SEW +: SEW];
        ax = {{SEW{a_sg & a[SEW-1]}}, a};
        bx = {{SEW{b_sg & b[SEW-1]}}, b};
        p  = ax * bx;
        r  = hi ? p[2*SEW-1:SEW] : p[SEW-1:0];
        if (!mask_q[e]) begin
          r = agn_q ? '1 : d;
        end
      end

      assign res_by[s][e*SEW +: SEW] = r;
    end
  end

  // SEW select; an out-of-range sel yields zero data and the error flag
  always_comb begin
    res_c = '0;
    err_c = 1'b1;
    for (int s = 0; s <= LOG; s++) begin
      if (sel_q == 3'(s)) begin
        res_c = res_by[s];
        err_c = 1'b0;
      end
    end
  end

  // stage valids: shift on advance, cleared by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
    end else if (flush_in) begin
      v_q <= '0;
    end else if (adv) begin
      if (STAGES > 1) begin
        v_q <= {v_q[STAGES-2:0], acc};
      end
    end
  end

  // operand capture stage, loaded only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      vd_q   <= '0;
      sel_q  <= '0;
      op_q   <= '0;
      mask_q <= '0;
      agn_q  <= 1'b0;
      tag0_q <= '0;
    end else if (acc) begin
      a_q    <= srca_in;
      b_q    <= srcb_in;
      vd_q   <= vd_in;
      sel_q  <= sel_in;
      op_q   <= op_in;
      mask_q <= mask_in;
      agn_q  <= mask_agn_in;
      tag0_q <= tag_in;
    end
  end

  // result/err/tag delay line; the whole pipe holds when not advancing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < STAGES; i++) begin
        res_q[i] <= '0;
        err_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else if (adv) begin
      res_q[1] <= res_c;
      err_q[1] <= err_c;
      tag_q[1] <= tag0_q;
      for (int i = 2; i < STAGES; i++) begin
        res_q[i] <= res_q[i-1];
        err_q[i] <= err_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // in-flight count: +1 on accept, -1 on output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else if (flush_in) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(acc) - OCC_W'(hs);
    end
  end

endmodule

// File: tb/tb_mulvec_pipe.sv
// tb_mulvec_pipe: scoreboard bench for mulvec_pipe
// directed vectors, backpressure, flush, reset and a random phase
module tb_mulvec_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] srca_in = '0;
  logic [127:0] srcb_in = '0;
  logic [127:0] vd_in = '0;
  logic [2:0]   sel_in = '0;
  logic [1:0]   op_in = '0;
  logic [15:0]  mask_in = '0;
  logic         mask_agn_in = 1'b0;
  logic [3:0]   tag_in = '0;
  logic         flush_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] result_out;
  logic         err_out;
  logic [3:0]   tag_out;
  logic [1:0]   occupancy_out;

  typedef struct {
    logic [127:0] res;
    logic         err;
    logic [3:0]   tag;
    int           acc;
    bit           lat;
  } sb_t;

  sb_t  q[$];
  sb_t  me;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   occ_max = 0;
  bit   rnd_rdy = 1'b0;

  mulvec_pipe #(.VLEN(128), .STAGES(3), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .srca_in(srca_in), .srcb_in(srcb_in), .vd_in(vd_in),
    .sel_in(sel_in), .op_in(op_in), .mask_in(mask_in),
    .mask_agn_in(mask_agn_in), .tag_in(tag_in),
    .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_out(result_out), .err_out(err_out),
    .tag_out(tag_out), .occupancy_out(occupancy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(
    input logic [127:0] a, input logic [127:0] b,
    input logic [127:0] vd, input logic [2:0] sel,
    input logic [1:0] op, input logic [15:0] mask, input logic agn);
    logic [127:0] r, m, ua, ub, ud, elt;
    logic signed [257:0] sa, sb, p, one;
    logic [257:0] sh;
    int sew, ne;
    bit asg, bsg;
    r = '0;
    if (sel > 3'd4) return r;
    sew = 8 << sel;
    ne  = 128 / sew;
    m   = (sew == 128) ? {128{1'b1}} : ((128'd1 << sew) - 128'd1);
    asg = (op == 2'b01) || (op == 2'b11);
    bsg = (op == 2'b01);
    one = 1;
    for (int i = 0; i < ne; i++) begin
      ua = (a >> (i * sew)) & m;
      ub = (b >> (i * sew)) & m;
      ud = (vd >> (i * sew)) & m;
      sa = {130'd0, ua};
      sb = {130'd0, ub};
      if (asg && ua[sew-1]) sa = sa - (one << sew);
      if (bsg && ub[sew-1]) sb = sb - (one << sew);
      p  = sa * sb;
      sh = (op == 2'b00) ? p : (p >> sew);
      elt = sh[127:0] & m;
      if (!mask[i]) elt = agn ? m : ud;
      r = r | (elt << (i * sew));
    end
    return r;
  endfunction

  // output monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && int'(occupancy_out) > occ_max) occ_max = int'(occupancy_out);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 128'd1, 128'd0);
      end else begin
        me = q.pop_front();
        chk("result", result_out, me.res);
        chk("err", 128'(err_out), 128'(me.err));
        chk("tag", 128'(tag_out), 128'(me.tag));
        if (me.lat) chk("latency", 128'(cyc - me.acc), 128'd3);
      end
    end
  end

  // random backpressure during the random phase
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // call at posedge+1; returns at posedge+1 after the accept
  task automatic send(input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] vd, input logic [2:0] sel,
                      input logic [1:0] op, input logic [15:0] mask,
                      input logic agn, input logic [3:0] tag,
                      input bit push, input bit lat);
    sb_t e;
    int n;
    srca_in = a; srcb_in = b; vd_in = vd;
    sel_in = sel; op_in = op; mask_in = mask;
    mask_agn_in = agn; tag_in = tag;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (push) begin
          e.res = model(a, b, vd, sel, op, mask, agn);
          e.err = (sel > 3'd4);
          e.tag = tag;
          e.acc = cyc;
          e.lat = lat;
          q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      n++;
      if (n > 60) begin
        chk("send_timeout", 128'd1, 128'd0);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 128'(q.size()), 128'd0);
    @(posedge clk); #1;
  endtask

  logic [127:0] held;
  logic [3:0]   held_tag;
  bit           held_ok;
  int           nacc;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_result", result_out, 128'd0);
    chk("rst_err", 128'(err_out), 128'd0);
    chk("rst_tag", 128'(tag_out), 128'd0);
    chk("rst_occ", 128'(occupancy_out), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // test 1: 0x7F * 0x02 in every byte
    send({16{8'h7F}}, {16{8'h02}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'h5, 1, 1);
    drain();

    // test 2: four back-to-back single-lane ops
    occ_max = 0;
    send(128'h80, 128'h80, '0, 3'd0, 2'b01, 16'hFFFF, 1'b0, 4'h1, 1, 1);
    send(128'hFF00, 128'hFF00, '0, 3'd0, 2'b10, 16'hFFFF, 1'b0, 4'h2, 1, 1);
    send(128'hFF0000, 128'hFF0000, '0, 3'd0, 2'b11, 16'hFFFF, 1'b0, 4'h3, 1, 1);
    send(128'h10000000, 128'h10000000, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'h4, 1, 1);
    drain();
    chk("occ_peak", 128'(occ_max), 128'd3);

    // test 3: halfword masking, both agnostic modes
    send({8{16'h0003}}, {8{16'h0003}}, {16{8'hA5}}, 3'd1, 2'b00,
         16'h0055, 1'b0, 4'h6, 1, 1);
    send({8{16'h0003}}, {8{16'h0003}}, {16{8'hA5}}, 3'd1, 2'b00,
         16'h0055, 1'b1, 4'h7, 1, 1);
    drain();

    // test 4: full-width MULHU, then illegal sel
    send(128'd1 << 127, 128'd1 << 127, '0, 3'd4, 2'b10, 16'hFFFF,
         1'b0, 4'h8, 1, 1);
    send(128'd1 << 127, 128'd1 << 127, '0, 3'd5, 2'b10, 16'hFFFF,
         1'b0, 4'h9, 1, 1);
    drain();

    // test 5: backpressure with five offered ops
    out_ready = 1'b0;
    nacc = 0;
    held_ok = 0;
    for (int k = 0; k < 5; k++) begin
      srca_in = {16{8'(k + 3)}};
      srcb_in = {16{8'(k + 11)}};
      vd_in = '0; sel_in = 3'd0; op_in = 2'b00;
      mask_in = 16'hFFFF; mask_agn_in = 1'b0;
      tag_in = 4'(k + 10);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        me.res = model(srca_in, srcb_in, vd_in, sel_in, op_in,
                       mask_in, mask_agn_in);
        me.err = 1'b0; me.tag = tag_in; me.acc = cyc; me.lat = 0;
        q.push_back(me);
        nacc++;
      end
      if (k == 3) chk("full_in_ready", 128'(in_ready), 128'd0);
      if (out_valid) begin
        if (!held_ok) begin
          held = result_out; held_tag = tag_out; held_ok = 1;
        end else begin
          chk("hold_result", result_out, held);
          chk("hold_tag", 128'(tag_out), 128'(held_tag));
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_result", result_out, held);
      @(posedge clk); #1;
    end
    chk("accepted", 128'(nacc), 128'd3);
    out_ready = 1'b1;
    drain();

    // test 6a: flush with two ops in flight
    send({16{8'h11}}, {16{8'h22}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'hA, 0, 0);
    send({16{8'h33}}, {16{8'h44}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'hB, 0, 0);
    flush_in = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    flush_in = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_occ", 128'(occupancy_out), 128'd0);
    repeat (4) begin
      chk("flush_no_out", 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send({16{8'h05}}, {16{8'h07}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'hC, 1, 1);
    drain();

    // test 6b: reset with two ops in flight
    send({16{8'h55}}, {16{8'h66}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'hD, 0, 0);
    send({16{8'h77}}, {16{8'h88}}, '0, 3'd0, 2'b00, 16'hFFFF,
         1'b0, 4'hE, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_occ", 128'(occupancy_out), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 128'(in_ready), 128'd1);
    repeat (4) begin
      chk("rst_no_out", 128'(out_valid), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send({8{16'h1234}}, {8{16'h0101}}, '0, 3'd1, 2'b10, 16'hFFFF,
         1'b0, 4'hF, 1, 1);
    drain();

    // random phase with random backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom},
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           16'($urandom), 1'($urandom_range(0, 1)),
           4'($urandom), 1, 0);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #3;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
